coordinate_2dto3d: RTL and testbench
====================================

COORDINATE_2DTO3D -- requirements
Module: coordinate_2DTO3D

Interface
REQ-001 SHALL have parameter RATE, default 19, meaning image-pixel to display-pixel scale (4000/208, integer).
REQ-002 SHALL have parameter FX, default 185, meaning focal length x (intrinsic [0][0]).
REQ-003 SHALL have parameter FY, default 185, meaning focal length y (intrinsic [1][1]).
REQ-004 SHALL have parameter CX, default 105, meaning principal point x (intrinsic [0][2]).
REQ-005 SHALL have parameter CY, default 77, meaning principal point y (intrinsic [1][2]).
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port in_valid  input  1  request carries valid x_2d/y_2d/z.
REQ-009 SHALL have port in_ready  output  1  block can accept a request.
REQ-010 SHALL have port x_2d  input  16  unsigned display x coordinate.
REQ-011 SHALL have port y_2d  input  16  unsigned display y coordinate.
REQ-012 SHALL have port z  input  16  signed depth.
REQ-013 SHALL have port out_valid  output  1  x/y result valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port x  output  32  signed camera-space x.
REQ-016 SHALL have port y  output  32  signed camera-space y.

Function
REQ-017 SHALL compute u=floor(x_2d/RATE), v=floor(y_2d/RATE), unsigned, 16 bit.
REQ-018 SHALL compute x=trunc((u-CX)*z/FX), y=trunc((v-CY)*z/FY); signed, quotient truncated toward zero; products in 32-bit signed (no overflow over full input range).
REQ-019 SHALL use one shared iterative restoring divider (one quotient bit per cycle); no combinational "/" operator.
REQ-020 SHALL implement FSM IDLE -> DIV_U (16 cycles) -> DIV_V (16) -> MUL (1) -> DIV_X (32) -> DIV_Y (32) -> DONE -> IDLE.
REQ-021 SHALL assert in_ready only in IDLE; acceptance = in_valid & in_ready on a rising edge; inputs captured into internal registers at acceptance.
REQ-022 SHALL ignore input changes after acceptance until return to IDLE.
REQ-023 SHALL assert out_valid exactly 98 cycles after the acceptance edge (97 compute cycles + DONE entry), fixed, data-independent.
REQ-024 SHALL hold x, y, out_valid stable in DONE while out_ready low.
REQ-025 SHALL leave DONE on out_valid & out_ready edge; out_valid low and in_ready high the following cycle; no same-cycle re-accept.
REQ-026 SHALL retain x, y at last result after handshake until next DONE.
REQ-027 SHALL divide magnitudes and apply sign = sign(u-CX) XOR sign(z); zero product yields 0 (incl. z=0).

Reset
REQ-028 SHALL on rst high at any edge (incl. mid-computation) force FSM to IDLE, in_ready=1 the cycle after rst deasserts, out_valid=0, x=0, y=0, discard in-flight request.
REQ-029 SHALL hold in_ready=0 while rst is high.

Verification
REQ-030 SHALL cover x_2d=3800, y_2d=1900, z=100 -> x=51, y=12, out_valid at cycle 98.
REQ-031 SHALL cover x_2d=0, y_2d=0, z=100 -> x=-56, y=-41 (truncation toward zero).
REQ-032 SHALL cover x_2d=3800, y_2d=1900, z=-200 -> x=-102, y=-24; and z=0 -> x=0, y=0.
REQ-033 SHALL cover x_2d=65535, z=32767 -> x=592285 (u=3449, no overflow).
REQ-034 SHALL cover out_ready low 10 cycles in DONE -> x/y/out_valid stable, in_ready=0; out_ready high -> in_ready=1 next cycle, back-to-back request accepted.
REQ-035 SHALL cover rst pulse at cycle 40 of a computation -> out_valid never asserted for that request, x=y=0, next request computes correctly.

Source files
------------

// File: rtl/coordinate_2dto3d.sv
// Back-projects a display pixel plus signed depth into camera-space x/y using
// one shared restoring divider that is time-multiplexed across four divides.
module coordinate_2dto3d #(
    parameter int RATE = 19,
    parameter int FX   = 185,
    parameter int FY   = 185,
    parameter int CX   = 105,
    parameter int CY   = 77
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        x_2d,
    input  logic [15:0]        y_2d,
    input  logic signed [15:0] z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] x,
    output logic signed [31:0] y
);

    typedef enum logic [2:0] {IDLE, DIV_U, DIV_V, MUL, DIV_X, DIV_Y, DONE} state_t;

    state_t             state;
    logic [4:0]         cnt;
    logic               rdy;
    logic [15:0]        yin;
    logic signed [15:0] zin;
    logic [15:0]        u, v;
    logic [31:0]        py_mag, qx;
    logic               neg_x, neg_y;

    // Divider: quo holds the not-yet-consumed dividend bits at the top and
    // collects quotient bits at the bottom; 16-bit divides preload dividend<<16.
    logic [31:0] rem, quo, dvs;
    logic [32:0] shifted, diff;
    logic [31:0] rem_nxt, quo_nxt;

    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvs};
        rem_nxt = diff[32] ? shifted[31:0] : diff[31:0];
        quo_nxt = {quo[30:0], ~diff[32]};
    end

    logic signed [31:0] du, dv, zx, px, py;

    always_comb begin
        du = $signed({16'd0, u}) - 32'(CX);
        dv = $signed({16'd0, v}) - 32'(CY);
        zx = {{16{zin[15]}}, zin};
        px = du * zx;
        py = dv * zx;
    end

    function automatic logic [31:0] mag(input logic signed [31:0] a);
        return a[31] ? -a : a;
    endfunction

    wire last16 = (cnt == 5'd15);
    wire last32 = (cnt == 5'd31);

    assign in_ready = rdy & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rdy       <= 1'b1;
            yin       <= '0;
            zin       <= '0;
            u         <= '0;
            v         <= '0;
            py_mag    <= '0;
            qx        <= '0;
            neg_x     <= 1'b0;
            neg_y     <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            out_valid <= 1'b0;
            x         <= '0;
            y         <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid && rdy) begin
                    yin   <= y_2d;
                    zin   <= z;
                    rem   <= '0;
                    quo   <= {x_2d, 16'd0};
                    dvs   <= 32'(RATE);
                    cnt   <= '0;
                    rdy   <= 1'b0;
                    state <= DIV_U;
                end
                DIV_U: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 5'd1;
                    if (last16) begin
                        u     <= quo_nxt[15:0];
                        rem   <= '0;
                        quo   <= {yin, 16'd0};
                        cnt   <= '0;
                        state <= DIV_V;
                    end
                end
                DIV_V: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 5'd1;
                    if (last16) begin
                        v     <= quo_nxt[15:0];
                        state <= MUL;
                    end
                end
                MUL: begin
                    // Divide magnitudes; a zero product gives zero whatever the sign.
                    neg_x  <= du[31] ^ zin[15];
                    neg_y  <= dv[31] ^ zin[15];
                    quo    <= mag(px);
                    py_mag <= mag(py);
                    rem    <= '0;
                    dvs    <= 32'(FX);
                    cnt    <= '0;
                    state  <= DIV_X;
                end
                DIV_X: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 5'd1;
                    if (last32) begin
                        qx    <= quo_nxt;
                        rem   <= '0;
                        quo   <= py_mag;
                        dvs   <= 32'(FY);
                        cnt   <= '0;
                        state <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 5'd1;
                    if (last32) state <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        x <= neg_x ? -$signed(qx)  : $signed(qx);
                        y <= neg_y ? -$signed(quo) : $signed(quo);
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        rdy       <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coordinate_2dto3d.sv
// Table, hand-sequence and random checks of coordinate_2dto3d against an
// integer-arithmetic reference.
`timescale 1ns/1ps
module tb_coordinate_2dto3d;

    localparam int RATE = 19, FX = 185, FY = 185, CX = 105, CY = 77;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        x_2d, y_2d;
    logic signed [15:0] z;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] x, y;

    coordinate_2dto3d #(.RATE(RATE), .FX(FX), .FY(FY), .CX(CX), .CY(CY)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_2d(x_2d), .y_2d(y_2d), .z(z), .out_valid(out_valid),
        .out_ready(out_ready), .x(x), .y(y)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0]        x2d;
        logic [15:0]        y2d;
        logic signed [15:0] zz;
        int                 ex;
        int                 ey;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Plain integer reference: SV int division truncates toward zero.
    task automatic model(input int x2d, input int y2d, input int zz, output int ex, output int ey);
        int uu, vv;
        uu = x2d / RATE;
        vv = y2d / RATE;
        ex = ((uu - CX) * zz) / FX;
        ey = ((vv - CY) * zz) / FY;
    endtask

    task automatic run_req(input logic [15:0] a, input logic [15:0] b, input logic signed [15:0] c,
                           input int stall, output int rx, output int ry);
        int  k;
        bit  busy;
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        x_2d = a; y_2d = b; z = c;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("accept_timeout", k, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_2d = 16'hbeef; y_2d = 16'h1234; z = -16'sd7;
        busy = 1'b0;
        for (k = 1; k <= 150; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
            if (in_ready) busy = 1'b1;
        end
        chk("latency", k, 98);
        chk("busy_in_ready", busy, 0);
        rx = x;
        ry = y;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_xy", {x, y}, {rx, ry});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_x_hold", x, rx);
    endtask

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int rx, ry, ex, ey;
        bit seen;
        logic [15:0] ra, rb;
        logic signed [15:0] rz;

        tbl[0] = '{16'd3800,  16'd1900, 16'sd100,    51,     12};
        tbl[1] = '{16'd0,     16'd0,    16'sd100,    -56,    -41};
        tbl[2] = '{16'd3800,  16'd1900, -16'sd200,   -102,   -24};
        tbl[3] = '{16'd3800,  16'd1900, 16'sd0,      0,      0};
        tbl[4] = '{16'd65535, 16'd0,    16'sd32767,  592285, -13638};
        tbl[5] = '{16'd1995,  16'd1463, -16'sd32768, 0,      0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x_2d = '0; y_2d = '0; z = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        foreach (tbl[i]) begin
            run_req(tbl[i].x2d, tbl[i].y2d, tbl[i].zz, 0, rx, ry);
            chk("tbl_x", rx, tbl[i].ex);
            chk("tbl_y", ry, tbl[i].ey);
        end

        // Consumer stalls 10 cycles, then a request follows back-to-back.
        run_req(16'd3800, 16'd1900, 16'sd100, 10, rx, ry);
        chk("stall_res_x", rx, 51);
        chk("stall_res_y", ry, 12);
        run_req(16'd0, 16'd0, 16'sd100, 0, rx, ry);
        chk("b2b_x", rx, -56);
        chk("b2b_y", ry, -41);

        // Reset at cycle 40 of a computation.
        in_valid = 1'b1; x_2d = 16'd3800; y_2d = 16'd1900; z = 16'sd100;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_x", x, 0);
        chk("midrst_y", y, 0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_valid", seen, 0);
        run_req(16'd3800, 16'd1900, -16'sd200, 0, rx, ry);
        chk("after_rst_x", rx, -102);
        chk("after_rst_y", ry, -24);

        for (int n = 0; n < 20; n++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rz = 16'($urandom());
            model(int'(ra), int'(rb), int'(rz), ex, ey);
            run_req(ra, rb, rz, (n % 4 == 0) ? 3 : 0, rx, ry);
            chk("rand_x", rx, ex);
            chk("rand_y", ry, ey);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
